// File: rtl/pong_physics.sv
// Frame-synchronous Pong physics: per frame_tick, moves paddles, then ball x
// (paddle bounce / scoring), then ball y (wall bounce), then pulses update_done.
module pong_physics #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 50,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       game_over,
  output logic       update_done
);

  localparam int CNT_W = (SERVE_FRAMES > 0) ? $clog2(SERVE_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);

  // All position maths is 11 bits wide so nothing wraps at the screen edges.
  localparam logic [10:0] BS      = 11'(BALL_SPEED);
  localparam logic [10:0] BSZ     = 11'(BALL_SIZE);
  localparam logic [10:0] PW      = 11'(PADDLE_W);
  localparam logic [10:0] PH      = 11'(PADDLE_H);
  localparam logic [10:0] SH      = 11'(SCREEN_H);
  localparam logic [10:0] P_SPD   = 11'(PADDLE_SPEED);
  localparam logic [10:0] P_MAX   = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] P_START = 11'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0] R_EDGE  = 11'(SCREEN_W - PADDLE_W);
  localparam logic [10:0] R_STOP  = 11'(SCREEN_W - PADDLE_W - BALL_SIZE);
  localparam logic [10:0] Y_STOP  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] CX      = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [10:0] CY      = 11'((SCREEN_H - BALL_SIZE) / 2);

  typedef enum logic [1:0] {S_WAIT, S_PADDLES, S_BALL, S_VCHECK} state_e;

  state_e           state_q, state_d;
  logic             do_paddles, do_ball, do_vcheck;
  logic [9:0]       ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [9:0]       p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic [3:0]       p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic             dx_right_q, dx_right_d, dy_down_q, dy_down_d;
  logic             skip_q, skip_d;
  logic             game_over_q, game_over_d;
  logic             update_done_q;
  logic [10:0]      bx, by, p1e, p2e;

  assign bx  = {1'b0, ball_x_q};
  assign by  = {1'b0, ball_y_q};
  assign p1e = {1'b0, p1_y_q};
  assign p2e = {1'b0, p2_y_q};

  function automatic logic [9:0] move_paddle(input logic [9:0] y, input logic up, input logic dn);
    logic [10:0] ye;
    logic [9:0]  res;
    ye  = {1'b0, y};
    res = y;
    if (up && !dn)      res = (ye <= P_SPD) ? 10'd0 : 10'(ye - P_SPD);
    else if (dn && !up) res = (ye + P_SPD >= P_MAX) ? 10'(P_MAX) : 10'(ye + P_SPD);
    return res;
  endfunction

  function automatic logic overlaps(input logic [10:0] ball_top, input logic [10:0] pad_top);
    return (ball_top + BSZ > pad_top) && (ball_top < pad_top + PH);
  endfunction

  function automatic logic [3:0] bump(input logic [3:0] s);
    return (s >= 4'd9) ? 4'd9 : s + 4'd1;
  endfunction

  // NOTE: clocked processes use non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:    if (frame_tick) state_d = S_PADDLES;
      S_PADDLES: state_d = S_BALL;
      S_BALL:    state_d = S_VCHECK;
      S_VCHECK:  state_d = S_WAIT;
      default:   state_d = S_WAIT;
    endcase
  end

  always_comb begin
    do_paddles = 1'b0;
    do_ball    = 1'b0;
    do_vcheck  = 1'b0;
    case (state_q)
      S_PADDLES: do_paddles = 1'b1;
      S_BALL:    do_ball    = 1'b1;
      S_VCHECK:  do_vcheck  = 1'b1;
      default:   ;
    endcase
  end

  // NOTE: every _d gets its hold value first, so no branch can infer a latch.
  always_comb begin
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    p1_y_d      = p1_y_q;
    p2_y_d      = p2_y_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    serve_cnt_d = serve_cnt_q;
    dx_right_d  = dx_right_q;
    dy_down_d   = dy_down_q;
    skip_d      = skip_q;
    game_over_d = game_over_q;

    if (do_paddles) begin
      p1_y_d = move_paddle(p1_y_q, p1_up, p1_down);
      p2_y_d = move_paddle(p2_y_q, p2_up, p2_down);
    end

    if (do_ball) begin
      skip_d = 1'b0;
      if (serve_cnt_q != '0 || game_over_q) begin
        if (serve_cnt_q != '0) serve_cnt_d = serve_cnt_q - CNT_W'(1);
        skip_d = 1'b1;
      end else if (!dx_right_q) begin
        if (bx <= PW + BS) begin
          if (overlaps(by, p1e)) begin
            ball_x_d   = 10'(PW);
            dx_right_d = 1'b1;
          end else begin
            p2_score_d  = bump(p2_score_q);
            ball_x_d    = 10'(CX);
            ball_y_d    = 10'(CY);
            serve_cnt_d = SERVE_LOAD;
            dx_right_d  = 1'b0;
            skip_d      = 1'b1;
          end
        end else begin
          ball_x_d = 10'(bx - BS);
        end
      end else begin
        if (bx + BSZ + BS >= R_EDGE) begin
          if (overlaps(by, p2e)) begin
            ball_x_d   = 10'(R_STOP);
            dx_right_d = 1'b0;
          end else begin
            // Serve toward the player who conceded.
            p1_score_d  = bump(p1_score_q);
            ball_x_d    = 10'(CX);
            ball_y_d    = 10'(CY);
            serve_cnt_d = SERVE_LOAD;
            dx_right_d  = 1'b1;
            skip_d      = 1'b1;
          end
        end else begin
          ball_x_d = 10'(bx + BS);
        end
      end
    end

    if (do_vcheck) begin
      if (!skip_q) begin
        if (!dy_down_q) begin
          if (by <= BS) begin
            ball_y_d  = 10'd0;
            dy_down_d = 1'b1;
          end else begin
            ball_y_d = 10'(by - BS);
          end
        end else begin
          if (by + BSZ + BS >= SH) begin
            ball_y_d  = 10'(Y_STOP);
            dy_down_d = 1'b0;
          end else begin
            ball_y_d = 10'(by + BS);
          end
        end
      end
      game_over_d = game_over_q | (p1_score_q == 4'd9) | (p2_score_q == 4'd9);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ball_x_q      <= 10'(CX);
      ball_y_q      <= 10'(CY);
      p1_y_q        <= 10'(P_START);
      p2_y_q        <= 10'(P_START);
      p1_score_q    <= 4'd0;
      p2_score_q    <= 4'd0;
      serve_cnt_q   <= SERVE_LOAD;
      dx_right_q    <= 1'b1;
      dy_down_q     <= 1'b1;
      skip_q        <= 1'b0;
      game_over_q   <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      p1_y_q        <= p1_y_d;
      p2_y_q        <= p2_y_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      serve_cnt_q   <= serve_cnt_d;
      dx_right_q    <= dx_right_d;
      dy_down_q     <= dy_down_d;
      skip_q        <= skip_d;
      game_over_q   <= game_over_d;
      update_done_q <= do_vcheck;
    end
  end

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign p1_y        = p1_y_q;
  assign p2_y        = p2_y_q;
  assign p1_score    = p1_score_q;
  assign p2_score    = p2_score_q;
  assign game_over   = game_over_q;
  assign update_done = update_done_q;

endmodule

// File: tb/tb_pong_physics.sv
// Directed bench for pong_physics: hand-traced ball trajectories with default
// parameters, covering serve hold, paddle limits, bounces, scoring and game over.
module tb_pong_physics;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [9:0] ball_x, ball_y, p1_y, p2_y;
  logic [3:0] p1_score, p2_score;
  logic       game_over, update_done;

  int   checks = 0;
  int   errors = 0;
  int   frame_no = 0;
  logic go_pre = 1'b0;

  pong_physics dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .frame_tick (frame_tick),
    .p1_up      (p1_up),
    .p1_down    (p1_down),
    .p2_up      (p2_up),
    .p2_down    (p2_down),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .game_over  (game_over),
    .update_done(update_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s (frame %0d): got %0d expected %0d", tag, frame_no, got, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, "_x"}, int'(ball_x), x);
    check({tag, "_y"}, int'(ball_y), y);
  endtask

  task automatic check_reset_state(input string tag);
    check_ball(tag, 316, 236);
    check({tag, "_p1_y"}, int'(p1_y), 215);
    check({tag, "_p2_y"}, int'(p2_y), 215);
    check({tag, "_p1_score"}, int'(p1_score), 0);
    check({tag, "_p2_score"}, int'(p2_score), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
    check({tag, "_update_done"}, int'(update_done), 0);
  endtask

  // One frame: pulse frame_tick for a cycle, then wait (bounded) for update_done.
  task automatic do_frame(input logic u1, input logic d1, input logic u2, input logic d2);
    logic seen;
    @(negedge CLOCK_50);
    p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (update_done) seen = 1'b1;
      else             go_pre = game_over;
    end
    frame_no++;
    check("frame_done", int'(seen), 1);
  endtask

  task automatic run_until(input int target, input logic u1, input logic d1,
                           input logic u2, input logic d2);
    while (frame_no < target) do_frame(u1, d1, u2, d2);
  endtask

  initial begin
    logic [7:0] trace;

    // ---- Reset state ----
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check_reset_state("rst");

    // ---- Serve hold with p1 climbing to the top ----
    for (int f = 1; f <= 60; f++) begin
      do_frame(1'b1, 1'b0, 1'b0, 1'b0);
      if (f == 53) check("p1_up_53", int'(p1_y), 3);
      if (f == 54) check("p1_up_54", int'(p1_y), 0);
    end
    check("p1_up_60", int'(p1_y), 0);
    check_ball("hold60", 316, 236);

    // ---- Frame 61: tick held 4 cycles, both buttons on both paddles ----
    @(negedge CLOCK_50);
    p1_up = 1'b1; p1_down = 1'b1; p2_up = 1'b1; p2_down = 1'b1;
    frame_tick = 1'b1;
    trace = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLOCK_50);
      trace[i-1] = update_done;
      if (i == 4) frame_tick = 1'b0;
    end
    frame_no++;
    check("done_trace", int'(trace), 8'h08);
    check_ball("first_move", 318, 238);
    check("both_p1", int'(p1_y), 0);
    check("both_p2", int'(p2_y), 215);

    // ---- Move p2 into the ball's path, then let the ball travel ----
    run_until(101, 1'b0, 1'b0, 1'b0, 1'b1);
    check("p2_down_40", int'(p2_y), 375);
    run_until(178, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("bottom_hit", 552, 472);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("bottom_after", 554, 470);
    run_until(212, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("pre_p2", 620, 404);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("p2_bounce", 622, 402);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("after_p2", 620, 400);

    // ---- Top wall at the y <= BALL_SPEED boundary ----
    run_until(413, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("pre_top", 222, 2);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("top_hit", 220, 0);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("top_after", 218, 2);

    // ---- Ball passes below p1 (at the top): p2 scores ----
    run_until(518, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("pre_left", 12, 208);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("p2_point", 316, 236);
    check("p2_point_s2", int'(p2_score), 1);
    check("p2_point_s1", int'(p1_score), 0);

    // ---- Fresh game: p1 scores every 213 frames until game over ----
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    frame_no = 0;
    run_until(213, 1'b0, 1'b0, 1'b0, 1'b0);
    check("p1_point_s1", int'(p1_score), 1);
    check("p1_point_s2", int'(p2_score), 0);
    check_ball("p1_point", 316, 236);
    run_until(273, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("serve_hold", 316, 236);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_ball("serve_go", 318, 234);
    run_until(1704, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s1_eight", int'(p1_score), 8);
    check("go_at_eight", int'(game_over), 0);
    run_until(1917, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s1_nine", int'(p1_score), 9);
    check("go_before_done", int'(go_pre), 0);
    check("go_at_done", int'(game_over), 1);
    check_ball("go_centre", 316, 236);

    // ---- Frozen ball after game over, paddles still live ----
    run_until(1987, 1'b0, 1'b0, 1'b0, 1'b0);
    do_frame(1'b1, 1'b0, 1'b0, 1'b0);
    do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    check_ball("frozen", 316, 236);
    check("go_paddle", int'(p1_y), 219);
    check("go_sticky", int'(game_over), 1);
    check("s1_sat", int'(p1_score), 9);

    // ---- Reset in the middle of a frame (state BALL) ----
    @(negedge CLOCK_50);
    p1_up = 1'b0; p1_down = 1'b1;
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    @(negedge CLOCK_50);
    check("mid_paddle", int'(p1_y), 223);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check_reset_state("mid_rst");
    reset = 1'b0;
    p1_down = 1'b0;
    trace = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLOCK_50);
      trace[i-1] = update_done;
    end
    check("no_done_after_abort", int'(trace), 0);
    check_reset_state("post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
